// File: rtl/mac_pkg.sv
// Shared types and constants for the multiplier / accumulator datapath.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int unsigned PROD_W    = 9;
   localparam int unsigned MAX_TERMS = 255;
   localparam int unsigned CNT_W     = 8;

endpackage

// File: rtl/sat_adder.sv
// Unsigned ACC_W + ACC_W adder that clamps to all-ones on carry-out.
module sat_adder #(
   parameter int unsigned ACC_W = 16
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum_c,
   output logic             sat_c
);

   logic [ACC_W:0] full;

   assign full  = {1'b0, a} + {1'b0, b};
   assign sat_c = full[ACC_W];
   assign sum_c = sat_c ? '1 : full[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums N_TERMS products from the multiplier into one result on a valid/ready port,
// with a one-entry pending buffer for products arriving while a result waits.
module product_accumulator
   import mac_pkg::*;
#(
   parameter int unsigned IN_W    = PROD_W,
   parameter int unsigned ACC_W   = 16,
   parameter int unsigned N_TERMS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic [IN_W-1:0]      prod_in,
   input  logic                 prod_valid,
   output logic [ACC_W-1:0]     acc_out,
   output logic                 acc_sat,
   output logic                 acc_valid,
   input  logic                 acc_ready,
   output logic [CNT_W-1:0]     term_cnt,
   output logic                 drop_err
);

   // Out-of-range term counts are clamped into the legal 2..MAX_TERMS window.
   localparam int unsigned TERMS = (N_TERMS < 2) ? 2 :
                                   (N_TERMS > MAX_TERMS) ? MAX_TERMS : N_TERMS;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS);

   state_t             state, state_nx;
   logic [ACC_W-1:0]   acc_nx;
   logic               sat_nx;
   logic               valid_nx;
   logic [CNT_W-1:0]   cnt_nx;
   logic               drop_nx;
   logic               pend_full, pend_full_nx;
   logic [IN_W-1:0]    pend_val, pend_val_nx;

   logic [ACC_W-1:0]   prod_ext;
   logic [ACC_W-1:0]   pend_ext;
   logic [ACC_W-1:0]   acc_sum;
   logic               acc_sum_sat;
   logic [ACC_W-1:0]   pend_sum;
   logic               pend_sum_sat;
   logic               handshake;
   logic [CNT_W-1:0]   cnt_inc;

   assign prod_ext  = ACC_W'(prod_in);
   assign pend_ext  = ACC_W'(pend_val);
   assign handshake = acc_valid && acc_ready;
   assign cnt_inc   = term_cnt + CNT_W'(1);

   sat_adder #(.ACC_W(ACC_W)) u_add_acc (
      .a     (acc_out),
      .b     (prod_ext),
      .sum_c (acc_sum),
      .sat_c (acc_sum_sat)
   );

   sat_adder #(.ACC_W(ACC_W)) u_add_pend (
      .a     (pend_ext),
      .b     (prod_ext),
      .sum_c (pend_sum),
      .sat_c (pend_sum_sat)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_nx     = state;
      acc_nx       = acc_out;
      sat_nx       = acc_sat;
      valid_nx     = acc_valid;
      cnt_nx       = term_cnt;
      drop_nx      = drop_err;
      pend_full_nx = pend_full;
      pend_val_nx  = pend_val;

      case (state)
         IDLE: begin
            if (prod_valid) begin
               acc_nx   = prod_ext;
               sat_nx   = 1'b0;
               cnt_nx   = CNT_W'(1);
               state_nx = ACCUM;
            end
         end

         ACCUM: begin
            if (prod_valid) begin
               acc_nx = acc_sum;
               sat_nx = acc_sat | acc_sum_sat;
               cnt_nx = cnt_inc;
               if (cnt_inc == LAST_CNT) begin
                  state_nx = HOLD;
                  valid_nx = 1'b1;
               end
            end
         end

         HOLD: begin
            if (handshake) begin
               pend_full_nx = 1'b0;
               valid_nx     = 1'b0;
               if (!pend_full && !prod_valid) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else if (!pend_full) begin
                  state_nx = ACCUM;
                  acc_nx   = prod_ext;
                  sat_nx   = 1'b0;
                  cnt_nx   = CNT_W'(1);
               end else if (!prod_valid) begin
                  state_nx = ACCUM;
                  acc_nx   = pend_ext;
                  sat_nx   = 1'b0;
                  cnt_nx   = CNT_W'(1);
               end else begin
                  acc_nx = pend_sum;
                  sat_nx = pend_sum_sat;
                  cnt_nx = CNT_W'(2);
                  if (LAST_CNT == CNT_W'(2)) begin
                     state_nx = HOLD;
                     valid_nx = 1'b1;
                  end else begin
                     state_nx = ACCUM;
                  end
               end
            end else if (prod_valid) begin
               if (!pend_full) begin
                  pend_full_nx = 1'b1;
                  pend_val_nx  = prod_in;
               end else begin
                  drop_nx = 1'b1;
               end
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State, datapath and output registers; clear behaves like reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc_out   <= '0;
         acc_sat   <= 1'b0;
         acc_valid <= 1'b0;
         term_cnt  <= '0;
         drop_err  <= 1'b0;
         pend_full <= 1'b0;
         pend_val  <= '0;
      end else if (clear) begin
         state     <= IDLE;
         acc_out   <= '0;
         acc_sat   <= 1'b0;
         acc_valid <= 1'b0;
         term_cnt  <= '0;
         drop_err  <= 1'b0;
         pend_full <= 1'b0;
         pend_val  <= '0;
      end else begin
         state     <= state_nx;
         acc_out   <= acc_nx;
         acc_sat   <= sat_nx;
         acc_valid <= valid_nx;
         term_cnt  <= cnt_nx;
         drop_err  <= drop_nx;
         pend_full <= pend_full_nx;
         pend_val  <= pend_val_nx;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop them on each handshake.
module tb_product_accumulator;

   typedef struct {
      logic [15:0] acc;
      logic        sat;
      logic [7:0]  cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;

   logic [8:0]  prod_in;
   logic        prod_valid;
   logic [15:0] acc_out;
   logic        acc_sat;
   logic        acc_valid;
   logic        acc_ready;
   logic [7:0]  term_cnt;
   logic        drop_err;

   logic [8:0]  prod_in_b;
   logic        prod_valid_b;
   logic [9:0]  acc_out_b;
   logic        acc_sat_b;
   logic        acc_valid_b;
   logic        acc_ready_b;
   logic [7:0]  term_cnt_b;
   logic        drop_err_b;

   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];
   exp_t exp_q_b[$];
   exp_t ea;
   exp_t eb;

   always #5 clk = ~clk;

   product_accumulator #(.IN_W(9), .ACC_W(16), .N_TERMS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .prod_in    (prod_in),
      .prod_valid (prod_valid),
      .acc_out    (acc_out),
      .acc_sat    (acc_sat),
      .acc_valid  (acc_valid),
      .acc_ready  (acc_ready),
      .term_cnt   (term_cnt),
      .drop_err   (drop_err)
   );

   product_accumulator #(.IN_W(9), .ACC_W(10), .N_TERMS(4)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .prod_in    (prod_in_b),
      .prod_valid (prod_valid_b),
      .acc_out    (acc_out_b),
      .acc_sat    (acc_sat_b),
      .acc_valid  (acc_valid_b),
      .acc_ready  (acc_ready_b),
      .term_cnt   (term_cnt_b),
      .drop_err   (drop_err_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int v);
      prod_valid = 1'b1;
      prod_in    = 9'(v);
      step();
      prod_valid = 1'b0;
   endtask

   task automatic send_b(input int v);
      prod_valid_b = 1'b1;
      prod_in_b    = 9'(v);
      step();
      prod_valid_b = 1'b0;
   endtask

   task automatic push(input int acc, input logic sat);
      exp_q.push_back('{acc: 16'(acc), sat: sat, cnt: 8'd4});
   endtask

   task automatic check_zero(input string name);
      check(name, {7'd0, acc_out, acc_sat, acc_valid, term_cnt, drop_err}, 32'd0);
   endtask

   // Monitor for the 16-bit instance: compare on every accepted result.
   always @(negedge clk) begin
      if (!rst && acc_valid && acc_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result: got acc_out=%0d, required no result", acc_out);
         end else begin
            ea = exp_q.pop_front();
            if (acc_out !== ea.acc || acc_sat !== ea.sat || term_cnt !== ea.cnt) begin
               fails++;
               $display("FAIL result: got acc=%0d sat=%0b cnt=%0d, required acc=%0d sat=%0b cnt=%0d",
                        acc_out, acc_sat, term_cnt, ea.acc, ea.sat, ea.cnt);
            end
         end
      end
   end

   // Monitor for the 10-bit saturation instance.
   always @(negedge clk) begin
      if (!rst && acc_valid_b && acc_ready_b) begin
         tests++;
         if (exp_q_b.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result_b: got acc_out=%0d, required no result", acc_out_b);
         end else begin
            eb = exp_q_b.pop_front();
            if (16'(acc_out_b) !== eb.acc || acc_sat_b !== eb.sat || term_cnt_b !== eb.cnt) begin
               fails++;
               $display("FAIL result_b: got acc=%0d sat=%0b cnt=%0d, required acc=%0d sat=%0b cnt=%0d",
                        acc_out_b, acc_sat_b, term_cnt_b, eb.acc, eb.sat, eb.cnt);
            end
         end
      end
   end

   initial begin
      rst          = 1'b1;
      clear        = 1'b0;
      prod_in      = '0;
      prod_valid   = 1'b0;
      acc_ready    = 1'b0;
      prod_in_b    = '0;
      prod_valid_b = 1'b0;
      acc_ready_b  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset_state");
      rst = 1'b0;
      step();

      // Basic accumulation with the consumer always ready.
      acc_ready = 1'b1;
      send(180); send(150); send(247);
      push(622, 1'b0);
      send(45);
      check("basic_latency_valid", {31'd0, acc_valid}, 32'd1);
      step();
      check("basic_valid_one_cycle", {31'd0, acc_valid}, 32'd0);

      // Backpressure: result held while a product lands in the pending buffer.
      acc_ready = 1'b0;
      send(180); send(150); send(247);
      push(622, 1'b0);
      send(45);
      for (int i = 0; i < 6; i++) begin
         if (i == 2) send(100);
         else step();
         check("hold_stable", {15'd0, acc_valid, acc_out}, {15'd0, 1'b1, 16'd622});
      end
      acc_ready = 1'b1;
      step();
      check("pending_restart", {7'd0, acc_valid, acc_out, term_cnt}, {7'd0, 1'b0, 16'd100, 8'd1});
      send(1); send(2);
      push(106, 1'b0);
      send(3);
      step();

      // Overflow loss: second product during HOLD is dropped.
      acc_ready = 1'b0;
      send(10); send(20); send(30);
      push(100, 1'b0);
      send(40);
      send(5);
      check("no_drop_first", {31'd0, drop_err}, 32'd0);
      send(7);
      check("drop_err_set", {31'd0, drop_err}, 32'd1);
      acc_ready = 1'b1;
      step();
      check("drop_restart", {8'd0, acc_out, term_cnt}, {8'd0, 16'd5, 8'd1});
      send(1); send(1);
      push(8, 1'b0);
      send(1);
      step();
      check("drop_err_sticky", {31'd0, drop_err}, 32'd1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_zero("clear_drop_err");

      // Simultaneous pending and new product on the handshake cycle.
      acc_ready = 1'b0;
      send(1); send(2); send(3);
      push(10, 1'b0);
      send(4);
      send(10);
      acc_ready = 1'b1;
      send(20);
      check("simultaneous", {7'd0, acc_valid, acc_out, term_cnt}, {7'd0, 1'b0, 16'd30, 8'd2});
      send(5);
      push(40, 1'b0);
      send(5);
      step();

      // Saturation on the 10-bit instance.
      acc_ready_b = 1'b1;
      send_b(465); send_b(465); send_b(465);
      exp_q_b.push_back('{acc: 16'd1023, sat: 1'b1, cnt: 8'd4});
      send_b(465);
      check("sat_flag", {21'd0, acc_sat_b, acc_out_b}, {21'd0, 1'b1, 10'd1023});
      step();
      send_b(1); send_b(2); send_b(3);
      exp_q_b.push_back('{acc: 16'd10, sat: 1'b0, cnt: 8'd4});
      send_b(4);
      check("sat_cleared", {31'd0, acc_sat_b}, 32'd0);
      step();

      // Asynchronous reset mid-accumulation.
      acc_ready = 1'b1;
      send(1); send(2);
      check("mid_term_cnt", {24'd0, term_cnt}, 32'd2);
      #3 rst = 1'b1;
      #1 check_zero("async_reset");
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) step();
      check("no_result_after_reset", {31'd0, acc_valid}, 32'd0);

      // Synchronous clear mid-accumulation; concurrent product ignored.
      send(1); send(2);
      clear      = 1'b1;
      prod_valid = 1'b1;
      prod_in    = 9'd50;
      step();
      clear      = 1'b0;
      prod_valid = 1'b0;
      check_zero("sync_clear");
      repeat (6) step();
      check("no_result_after_clear", {31'd0, acc_valid}, 32'd0);

      check("scoreboard_drained", 32'(exp_q.size() + exp_q_b.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
